// File: rtl/mips_decode_exec.sv
// Decode-and-execute slice of the single-cycle MIPS core.
// Main control, ALU control and ALU are combinational. The result and zero
// flag are also captured in a clock-enabled register.
module mips_decode_exec #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic [31:0]      instr,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             reg_dst,
  output logic             branch,
  output logic             mem_read,
  output logic             mem_to_reg,
  output logic             mem_write,
  output logic             alu_src,
  output logic             reg_write,
  output logic [1:0]       alu_op,
  output logic [3:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_result,
  output logic             z_flag,
  output logic [WIDTH-1:0] result_q,
  output logic             z_q
);

  localparam int unsigned IMM_W = 16;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDIU = 6'h09;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_INV  = 4'b1111;

  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic [WIDTH-1:0] imm_zx;
  logic             unused_instr;

  assign opcode       = instr[31:26];
  assign funct        = instr[5:0];
  assign unused_instr = ^instr[25:16];

  // Immediate operand is zero-extended, never sign-extended
  assign imm_zx = {{(WIDTH-IMM_W){1'b0}}, instr[IMM_W-1:0]};
  assign op1    = rs_data;
  assign op2    = alu_src ? imm_zx : rt_data;

  // Main control: opcode to datapath controls; unknown opcodes drive all zero
  always_comb begin
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    branch     = 1'b0;
    alu_op     = 2'b00;
    unique case (opcode)
      OP_RTYPE: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        alu_op    = 2'b10;
      end
      OP_LW: begin
        alu_src    = 1'b1;
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        mem_read   = 1'b1;
      end
      OP_SW: begin
        alu_src   = 1'b1;
        mem_write = 1'b1;
      end
      OP_BEQ: begin
        branch = 1'b1;
        alu_op = 2'b01;
      end
      OP_ADDIU: begin
        alu_src   = 1'b1;
        reg_write = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU control: class plus funct field to ALU operation
  always_comb begin
    alu_ctrl = ALU_ADD;
    unique case (alu_op)
      2'b01: alu_ctrl = ALU_SUB;
      2'b10: begin
        unique case (funct)
          6'h20, 6'h21: alu_ctrl = ALU_ADD;
          6'h22, 6'h23: alu_ctrl = ALU_SUB;
          6'h24:        alu_ctrl = ALU_AND;
          6'h25:        alu_ctrl = ALU_OR;
          6'h26:        alu_ctrl = ALU_XOR;
          6'h27:        alu_ctrl = ALU_NOR;
          6'h2A:        alu_ctrl = ALU_SLT;
          6'h2B:        alu_ctrl = ALU_SLTU;
          default:      alu_ctrl = ALU_INV;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

  // ALU datapath; add/sub wrap with no overflow detection
  always_comb begin
    alu_result = '0;
    unique case (alu_ctrl)
      ALU_AND:  alu_result = op1 & op2;
      ALU_OR:   alu_result = op1 | op2;
      ALU_ADD:  alu_result = op1 + op2;
      ALU_XOR:  alu_result = op1 ^ op2;
      ALU_SUB:  alu_result = op1 - op2;
      ALU_SLT:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
      ALU_SLTU: alu_result = {{(WIDTH-1){1'b0}}, (op1 < op2)};
      ALU_NOR:  alu_result = ~(op1 | op2);
      default:  alu_result = '0;
    endcase
  end

  assign z_flag = (alu_result == '0);

  // Output register: reset wins over enable, otherwise hold when disabled
  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      z_q      <= 1'b0;
    end else if (clk_enable) begin
      result_q <= alu_result;
      z_q      <= z_flag;
    end
  end

endmodule

// File: tb/tb_mips_decode_exec.sv
// Directed bench for mips_decode_exec: combinational outputs checked against
// constants, registered outputs checked through an expected-value queue.
module tb_mips_decode_exec;

  logic        clk;
  logic        reset;
  logic        clk_enable;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
  logic [1:0]  alu_op;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        z_flag;
  logic [31:0] result_q;
  logic        z_q;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [32:0] sb_q[$];
  logic [31:0] last_r;
  logic        last_z;

  mips_decode_exec #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .instr      (instr),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .reg_dst    (reg_dst),
    .branch     (branch),
    .mem_read   (mem_read),
    .mem_to_reg (mem_to_reg),
    .mem_write  (mem_write),
    .alu_src    (alu_src),
    .reg_write  (reg_write),
    .alu_op     (alu_op),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .z_flag     (z_flag),
    .result_q   (result_q),
    .z_q        (z_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Controls packed as {reg_dst,alu_src,mem_to_reg,reg_write,mem_read,mem_write,branch,alu_op}
  task automatic chk_ctl(input string tag, input logic [8:0] exp);
    chk(tag, 32'({reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op}),
        32'(exp));
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    instr   = ins;
    rs_data = a;
    rt_data = b;
    #1;
  endtask

  task automatic push(input logic [31:0] r, input logic z);
    sb_q.push_back({z, r});
    last_r = r;
    last_z = z;
  endtask

  // Advance one edge and compare registered outputs with the oldest expectation
  task automatic tick(input string tag);
    logic [32:0] e;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s: observed empty scoreboard expected entry", tag);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_rq"}, result_q, e[31:0]);
      chk({tag, "_zq"}, 32'(z_q), 32'(e[32]));
    end
  endtask

  initial begin
    reset      = 1'b1;
    clk_enable = 1'b0;
    last_r     = '0;
    last_z     = 1'b0;
    drive(32'h0, 32'h0, 32'h0);
    @(negedge clk);
    push(32'h0, 1'b0);
    tick("reset");
    reset = 1'b0;

    // R-type add
    clk_enable = 1'b1;
    drive(32'h00853020, 32'd5, 32'd7);
    chk_ctl("add_ctl", 9'b100100010);
    chk("add_aluctrl", 32'(alu_ctrl), 32'h2);
    chk("add_res", alu_result, 32'd12);
    chk("add_z", 32'(z_flag), 32'h0);
    push(32'd12, 1'b0);
    tick("add");

    // addu wrap
    drive(32'h00853021, 32'hFFFFFFFF, 32'd1);
    chk("addu_res", alu_result, 32'h0);
    chk("addu_z", 32'(z_flag), 32'h1);
    push(32'h0, 1'b1);
    tick("addu");

    // SLT vs SLTU
    drive(32'h0085302A, 32'hFFFFFFFF, 32'd1);
    chk("slt_ctrl", 32'(alu_ctrl), 32'h7);
    chk("slt_res", alu_result, 32'd1);
    drive(32'h0085302B, 32'hFFFFFFFF, 32'd1);
    chk("sltu_ctrl", 32'(alu_ctrl), 32'h8);
    chk("sltu_res", alu_result, 32'd0);
    drive(32'h0085302A, 32'd1, 32'hFFFFFFFF);
    chk("slt2_res", alu_result, 32'd0);
    drive(32'h0085302B, 32'd1, 32'hFFFFFFFF);
    chk("sltu2_res", alu_result, 32'd1);

    // sub / subu
    drive(32'h00853022, 32'd3, 32'd5);
    chk("sub_ctrl", 32'(alu_ctrl), 32'h6);
    chk("sub_res", alu_result, 32'hFFFFFFFE);
    drive(32'h00853023, 32'd9, 32'd9);
    chk("subu_res", alu_result, 32'h0);
    chk("subu_z", 32'(z_flag), 32'h1);

    // lw / sw with zero-extended immediate
    drive(32'h8C82FFFC, 32'h100, 32'hDEAD0000);
    chk_ctl("lw_ctl", 9'b011110000);
    chk("lw_res", alu_result, 32'h000100FC);
    push(32'h000100FC, 1'b0);
    tick("lw");
    drive(32'hAC82FFFC, 32'h100, 32'hDEAD0000);
    chk_ctl("sw_ctl", 9'b010001000);
    chk("sw_res", alu_result, 32'h000100FC);

    // addiu immediate with bit 15 set stays positive
    drive(32'h24838000, 32'd1, 32'h0);
    chk_ctl("addiu_ctl", 9'b010100000);
    chk("addiu_res", alu_result, 32'h00008001);

    // beq equal / not equal
    drive(32'h10850003, 32'h1234, 32'h1234);
    chk_ctl("beq_ctl", 9'b000000101);
    chk("beq_ctrl", 32'(alu_ctrl), 32'h6);
    chk("beq_z", 32'(z_flag), 32'h1);
    drive(32'h10850003, 32'h1234, 32'h1235);
    chk("bne_z", 32'(z_flag), 32'h0);
    chk("bne_res", alu_result, 32'hFFFFFFFF);
    push(32'hFFFFFFFF, 1'b0);
    tick("beq");

    // Logic ops
    drive(32'h00853024, 32'hF0F0F0F0, 32'h0FF00FF0);
    chk("and_ctrl", 32'(alu_ctrl), 32'h0);
    chk("and_res", alu_result, 32'h00F000F0);
    drive(32'h00853025, 32'hF0F0F0F0, 32'h0FF00FF0);
    chk("or_ctrl", 32'(alu_ctrl), 32'h1);
    chk("or_res", alu_result, 32'hFFF0FFF0);
    drive(32'h00853026, 32'hF0F0F0F0, 32'h0FF00FF0);
    chk("xor_ctrl", 32'(alu_ctrl), 32'h3);
    chk("xor_res", alu_result, 32'hFF00FF00);
    drive(32'h00853027, 32'hF0F0F0F0, 32'h0FF00FF0);
    chk("nor_ctrl", 32'(alu_ctrl), 32'hC);
    chk("nor_res", alu_result, 32'h000F000F);
    push(32'h000F000F, 1'b0);
    tick("nor");

    // Invalid funct and unknown opcode
    drive(32'h0085303F, 32'h55, 32'h66);
    chk("inv_ctrl", 32'(alu_ctrl), 32'hF);
    chk("inv_res", alu_result, 32'h0);
    chk("inv_z", 32'(z_flag), 32'h1);
    drive(32'hFC000000, 32'd3, 32'd4);
    chk_ctl("badop_ctl", 9'b000000000);
    chk("badop_ctrl", 32'(alu_ctrl), 32'h2);
    chk("badop_res", alu_result, 32'd7);

    // Hold when disabled while alu_result changes
    push(32'd7, 1'b0);
    tick("pre_hold");
    clk_enable = 1'b0;
    drive(32'h00853020, 32'd100, 32'd200);
    chk("hold_comb", alu_result, 32'd300);
    push(last_r, last_z);
    tick("hold");

    // Reset overrides enable
    clk_enable = 1'b1;
    reset = 1'b1;
    push(32'h0, 1'b0);
    tick("rst_en");
    reset = 1'b0;
    drive(32'h00853023, 32'd4, 32'd4);
    push(32'h0, 1'b1);
    tick("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
